// File: rtl/io_pkg.sv
// Shared I/O constants for the accumulator core
// and its output buffer.
package io_pkg;

  localparam int IO_DATA_W     = 16;
  localparam int IO_FIFO_DEPTH = 8;

endpackage

// File: rtl/io_fifo_mem.sv
// Register-array storage for the output FIFO:
// one write port, one asynchronous read port.
module io_fifo_mem
  import io_pkg::*;
#(
  parameter int DATA_W = IO_DATA_W,
  parameter int DEPTH  = IO_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage is qualified by the pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/io_output_buffer.sv
// First-word-fall-through FIFO between the core's
// IOOut port and a valid/ready output consumer.
module io_output_buffer
  import io_pkg::*;
#(
  parameter int DATA_W = IO_DATA_W,
  parameter int DEPTH  = IO_FIFO_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  input  logic              clr_overflow,
  output logic [DATA_W-1:0] last_value
);

  localparam int AW = $clog2(DEPTH);

  logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] last_value_q, last_value_d;
  logic              push, pop, drop;
  logic [DATA_W-1:0] rdata;

  // Extra pointer MSB tells full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  =
    (wr_ptr_q[CNT_W-1] != rd_ptr_q[CNT_W-1]) &&
    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

  assign out_valid = ~empty;
  assign pop  = out_valid & out_ready;
  assign push = wr_en & (~full | pop);
  assign drop = wr_en & full & ~pop;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    overflow_d   = overflow_q;
    last_value_d = last_value_q;
    if (push) wr_ptr_d = wr_ptr_q + CNT_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + CNT_W'(1);
    if (clr_overflow) overflow_d = 1'b0;
    if (drop) overflow_d = 1'b1;
    if (wr_en) last_value_d = wr_data;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      last_value_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      last_value_q <= last_value_d;
    end
  end

  io_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (CLK),
    .we    (push),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rdata)
  );

  assign out_data   = empty ? '0 : rdata;
  assign overflow   = overflow_q;
  assign last_value = last_value_q;

endmodule

// File: tb/tb_io_output_buffer.sv
// Scoreboard bench for io_output_buffer:
// expected words queued at issue, checked on pop.
module tb_io_output_buffer;

  logic        CLK = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        overflow;
  logic        clr_overflow;
  logic [15:0] last_value;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q [$];

  io_output_buffer dut (
    .CLK          (CLK),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .last_value   (last_value)
  );

  always #5 CLK = ~CLK;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic put(input logic [15:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    cyc();
    wr_en = 1'b0;
  endtask

  // Monitor: every completed handshake pops one
  // expected word.
  always @(negedge CLK) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected: got %h expected none",
                 out_data);
      end else begin
        chk("pop_data", 32'(out_data),
            32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset        = 1'b0;
    wr_en        = 1'b0;
    wr_data      = '0;
    out_ready    = 1'b0;
    clr_overflow = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_last", 32'(last_value), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    cyc();
    reset = 1'b1;
    cyc();

    // single write, latency 1
    put(16'h1234);
    @(negedge CLK);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'h1234);
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_last", 32'(last_value), 32'h1234);
    cyc();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    @(negedge CLK);
    chk("t1_empty", 32'(empty), 32'd1);
    cyc();

    // fill to full
    for (int i = 1; i <= 8; i++) put(16'(i));
    @(negedge CLK);
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_count", 32'(count), 32'd8);
    chk("t2_empty", 32'(empty), 32'd0);
    cyc();

    // dropped write while full
    wr_en   = 1'b1;
    wr_data = 16'hDEAD;
    cyc();
    wr_en = 1'b0;
    @(negedge CLK);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_last", 32'(last_value), 32'hDEAD);
    chk("t3_count", 32'(count), 32'd8);
    chk("t3_head", 32'(out_data), 32'h0001);
    cyc();
    clr_overflow = 1'b1;
    cyc();
    clr_overflow = 1'b0;
    @(negedge CLK);
    chk("t3_clr", 32'(overflow), 32'd0);
    cyc();

    // drop and clear together: set wins
    wr_en        = 1'b1;
    wr_data      = 16'hBAD0;
    clr_overflow = 1'b1;
    cyc();
    wr_en        = 1'b0;
    clr_overflow = 1'b0;
    @(negedge CLK);
    chk("t3_setwins", 32'(overflow), 32'd1);
    chk("t3_last2", 32'(last_value), 32'hBAD0);
    cyc();
    clr_overflow = 1'b1;
    cyc();
    clr_overflow = 1'b0;

    // push + pop while full
    out_ready = 1'b1;
    put(16'h0009);
    out_ready = 1'b0;
    @(negedge CLK);
    chk("t4_count", 32'(count), 32'd8);
    chk("t4_full", 32'(full), 32'd1);
    chk("t4_ovf", 32'(overflow), 32'd0);
    chk("t4_head", 32'(out_data), 32'h0002);
    cyc();

    // drain 0x0002..0x0009
    out_ready = 1'b1;
    repeat (8) cyc();
    out_ready = 1'b0;
    @(negedge CLK);
    chk("t2_drain_empty", 32'(empty), 32'd1);
    chk("t2_drain_count", 32'(count), 32'd0);
    chk("t2_drain_valid", 32'(out_valid), 32'd0);
    cyc();

    // streaming push+pop across pointer wrap
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_en   = 1'b1;
      wr_data = 16'h0100 + 16'(i);
      exp_q.push_back(wr_data);
      @(posedge CLK);
      @(negedge CLK);
      chk("t5_count", 32'(count), 32'd1);
      chk("t5_full", 32'(full), 32'd0);
      chk("t5_empty", 32'(empty), 32'd0);
    end
    wr_en = 1'b0;
    cyc();
    out_ready = 1'b0;
    @(negedge CLK);
    chk("t5_empty_end", 32'(empty), 32'd1);
    cyc();

    // reset mid-stream
    for (int i = 0; i < 5; i++) put(16'h0A00 + 16'(i));
    @(negedge CLK);
    chk("t6_count5", 32'(count), 32'd5);
    @(posedge CLK);
    #3;
    reset = 1'b0;
    #1;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    exp_q.delete();
    cyc();
    reset = 1'b1;
    cyc();
    put(16'hBEEF);
    @(negedge CLK);
    chk("t6_count1", 32'(count), 32'd1);
    chk("t6_head", 32'(out_data), 32'hBEEF);
    cyc();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    @(negedge CLK);
    chk("t6_empty_end", 32'(empty), 32'd1);
    chk("sb_left", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
